// File: rtl/rob_commit_if.sv
// Dispatch, completion, flush, commit and window-status signals of the
// reorder buffer, bundled so the commit stage and its neighbours share one bus.
interface rob_commit_if #(
  parameter int ROB_W  = 3,
  parameter int REG_W  = 4,
  parameter int DATA_W = 8
);
  logic              alloc_valid;
  logic              alloc_dst_valid;
  logic [REG_W-1:0]  alloc_dst_addr;
  logic              alloc_ready;
  logic [ROB_W-1:0]  alloc_rob_addr;
  logic              cmpl_valid;
  logic [ROB_W-1:0]  cmpl_rob_addr;
  logic [DATA_W-1:0] cmpl_data;
  logic              flush_valid;
  logic [ROB_W-1:0]  flush_rob_addr;
  logic              commit_valid;
  logic [ROB_W-1:0]  commit_rob_addr;
  logic              commit_dst_valid;
  logic [REG_W-1:0]  commit_dst_addr;
  logic [DATA_W-1:0] commit_data;
  logic [ROB_W-1:0]  head_addr;
  logic [ROB_W:0]    count;
  logic              full;
  logic              empty;

  // Dispatch/execute/branch side: drives requests, observes the ROB.
  modport master (
    output alloc_valid, alloc_dst_valid, alloc_dst_addr,
    output cmpl_valid, cmpl_rob_addr, cmpl_data,
    output flush_valid, flush_rob_addr,
    input  alloc_ready, alloc_rob_addr,
    input  commit_valid, commit_rob_addr, commit_dst_valid, commit_dst_addr, commit_data,
    input  head_addr, count, full, empty
  );

  // ROB side.
  modport slave (
    input  alloc_valid, alloc_dst_valid, alloc_dst_addr,
    input  cmpl_valid, cmpl_rob_addr, cmpl_data,
    input  flush_valid, flush_rob_addr,
    output alloc_ready, alloc_rob_addr,
    output commit_valid, commit_rob_addr, commit_dst_valid, commit_dst_addr, commit_data,
    output head_addr, count, full, empty
  );
endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer with single-retire commit stage. Pointers carry a
// wrap bit so a full window (tail-head == DEPTH) is distinct from empty.
module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int ROB_W  = 3,
  parameter int REG_W  = 4,
  parameter int DATA_W = 8
) (
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave bus
);
  localparam logic [ROB_W:0] DEPTH_C = (ROB_W+1)'(DEPTH);

  logic [ROB_W:0]    head, tail, cnt, flush_tail;
  logic [ROB_W-1:0]  head_idx, tail_idx, cmpl_off, flush_off;
  logic [DEPTH-1:0]  busy, done, dst_valid, squash;
  logic [REG_W-1:0]  dst_addr [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic              is_full, is_empty, cmpl_live, flush_act, cmpl_act;
  logic              alloc_fire, commit_fire;

  // Window bookkeeping: occupancy, liveness of cmpl/flush targets, squash set.
  always_comb begin
    head_idx   = head[ROB_W-1:0];
    tail_idx   = tail[ROB_W-1:0];
    cnt        = tail - head;
    is_full    = (cnt == DEPTH_C);
    is_empty   = (cnt == '0);
    cmpl_off   = bus.cmpl_rob_addr - head_idx;
    flush_off  = bus.flush_rob_addr - head_idx;
    cmpl_live  = ({1'b0, cmpl_off} < cnt);
    flush_act  = bus.flush_valid & ({1'b0, flush_off} < cnt);
    flush_tail = head + (ROB_W+1)'(flush_off) + (ROB_W+1)'(1);
    squash     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = flush_act
                  && ((ROB_W'(i) - head_idx) > flush_off)
                  && ({1'b0, ROB_W'(i) - head_idx} < cnt);
    end
    // A completion aimed at an entry squashed this same cycle is dropped.
    cmpl_act    = bus.cmpl_valid & cmpl_live & ~squash[bus.cmpl_rob_addr];
    // Flush takes priority over dispatch; full comes from registered pointers,
    // so a same-cycle retire does not open a slot until the next cycle.
    alloc_fire  = bus.alloc_valid & ~is_full & ~bus.flush_valid;
    commit_fire = ~rst & ~is_empty & busy[head_idx] & done[head_idx];
  end

  // Pointers and per-entry status; the head is always kept by a flush, so its
  // retire proceeds in parallel.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      done <= '0;
    end else begin
      if (alloc_fire) begin
        busy[tail_idx] <= 1'b1;
        done[tail_idx] <= 1'b0;
      end
      if (cmpl_act) done[bus.cmpl_rob_addr] <= 1'b1;
      if (commit_fire) begin
        busy[head_idx] <= 1'b0;
        done[head_idx] <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (squash[i]) begin
          busy[i] <= 1'b0;
          done[i] <= 1'b0;
        end
      end
      head <= head + (ROB_W+1)'(commit_fire);
      tail <= flush_act ? flush_tail : tail + (ROB_W+1)'(alloc_fire);
    end
  end

  // Entry payload; only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dst_valid[tail_idx] <= bus.alloc_dst_valid;
      dst_addr[tail_idx]  <= bus.alloc_dst_addr;
    end
    if (cmpl_act) data[bus.cmpl_rob_addr] <= bus.cmpl_data;
  end

  assign bus.alloc_ready      = ~is_full & ~bus.flush_valid;
  assign bus.alloc_rob_addr   = tail_idx;
  assign bus.commit_valid     = commit_fire;
  assign bus.commit_rob_addr  = head_idx;
  assign bus.commit_dst_valid = dst_valid[head_idx];
  assign bus.commit_dst_addr  = dst_addr[head_idx];
  assign bus.commit_data      = data[head_idx];
  assign bus.head_addr        = head_idx;
  assign bus.count            = cnt;
  assign bus.full             = is_full;
  assign bus.empty            = is_empty;
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit (DEPTH=8): a per-cycle vector table for
// in-order and out-of-order retire, then hand sequences for reset, full/wrap,
// flush and same-cycle priority corners.
module tb_rob_commit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  rob_commit_if #(.ROB_W(3), .REG_W(4), .DATA_W(8)) bus ();

  rob_commit #(.DEPTH(8), .ROB_W(3), .REG_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [3:0] ada;
    logic       cv;
    logic [2:0] ca;
    logic [7:0] cd;
    logic       e_rdy;
    logic [2:0] e_aa;
    logic       e_cv;
    logic [3:0] e_cdst;
    logic [7:0] e_cd;
    logic [3:0] e_cnt;
    logic [2:0] e_head;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic av, logic [3:0] ada, logic cv, logic [2:0] ca,
                              logic [7:0] cd, logic rdy, logic [2:0] aa, logic ecv,
                              logic [3:0] cdst, logic [7:0] ecd, logic [3:0] cnt,
                              logic [2:0] hd);
    vec_t v;
    v.av = av; v.ada = ada; v.cv = cv; v.ca = ca; v.cd = cd;
    v.e_rdy = rdy; v.e_aa = aa; v.e_cv = ecv; v.e_cdst = cdst; v.e_cd = ecd;
    v.e_cnt = cnt; v.e_head = hd;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst                 = 1'b0;
    bus.alloc_valid     = 1'b0;
    bus.alloc_dst_valid = 1'b0;
    bus.alloc_dst_addr  = '0;
    bus.cmpl_valid      = 1'b0;
    bus.cmpl_rob_addr   = '0;
    bus.cmpl_data       = '0;
    bus.flush_valid     = 1'b0;
    bus.flush_rob_addr  = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic set_alloc(input logic [3:0] dst);
    bus.alloc_valid     = 1'b1;
    bus.alloc_dst_valid = 1'b1;
    bus.alloc_dst_addr  = dst;
  endtask

  task automatic set_cmpl(input logic [2:0] a, input logic [7:0] d);
    bus.cmpl_valid    = 1'b1;
    bus.cmpl_rob_addr = a;
    bus.cmpl_data     = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    //             av ada cv ca cd      rdy aa cv dst data  cnt hd
    vecs[0]  = mk(0, 0, 0, 0, 8'h00,   1, 0, 0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 8'h00,   1, 0, 0, 0, 8'h00, 0, 0);
    vecs[2]  = mk(1, 2, 0, 0, 8'h00,   1, 1, 0, 0, 8'h00, 1, 0);
    vecs[3]  = mk(1, 3, 0, 0, 8'h00,   1, 2, 0, 0, 8'h00, 2, 0);
    vecs[4]  = mk(0, 0, 1, 0, 8'h11,   1, 3, 0, 0, 8'h00, 3, 0);
    vecs[5]  = mk(0, 0, 1, 1, 8'h22,   1, 3, 1, 1, 8'h11, 3, 0);
    vecs[6]  = mk(0, 0, 1, 2, 8'h33,   1, 3, 1, 2, 8'h22, 2, 1);
    vecs[7]  = mk(0, 0, 0, 0, 8'h00,   1, 3, 1, 3, 8'h33, 1, 2);
    vecs[8]  = mk(1, 4, 0, 0, 8'h00,   1, 3, 0, 0, 8'h00, 0, 3);
    vecs[9]  = mk(1, 5, 0, 0, 8'h00,   1, 4, 0, 0, 8'h00, 1, 3);
    vecs[10] = mk(1, 6, 0, 0, 8'h00,   1, 5, 0, 0, 8'h00, 2, 3);
    vecs[11] = mk(0, 0, 1, 5, 8'h55,   1, 6, 0, 0, 8'h00, 3, 3);
    vecs[12] = mk(0, 0, 1, 4, 8'h44,   1, 6, 0, 0, 8'h00, 3, 3);
    vecs[13] = mk(0, 0, 0, 0, 8'h00,   1, 6, 0, 0, 8'h00, 3, 3);
    vecs[14] = mk(0, 0, 1, 3, 8'h40,   1, 6, 0, 0, 8'h00, 3, 3);
    vecs[15] = mk(0, 0, 0, 0, 8'h00,   1, 6, 1, 4, 8'h40, 3, 3);
    vecs[16] = mk(0, 0, 0, 0, 8'h00,   1, 6, 1, 5, 8'h44, 2, 4);
    vecs[17] = mk(0, 0, 1, 2, 8'hEE,   1, 6, 1, 6, 8'h55, 1, 5);
    vecs[18] = mk(0, 0, 0, 0, 8'h00,   1, 6, 0, 0, 8'h00, 0, 6);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    idle();

    // Table: in-order retire, then out-of-order completion with wrap start.
    for (int i = 0; i < 19; i++) begin
      bus.alloc_valid     = vecs[i].av;
      bus.alloc_dst_valid = vecs[i].av;
      bus.alloc_dst_addr  = vecs[i].ada;
      bus.cmpl_valid      = vecs[i].cv;
      bus.cmpl_rob_addr   = vecs[i].ca;
      bus.cmpl_data       = vecs[i].cd;
      #1;
      chk($sformatf("v%0d_alloc_ready", i), int'(bus.alloc_ready), int'(vecs[i].e_rdy));
      chk($sformatf("v%0d_alloc_addr", i), int'(bus.alloc_rob_addr), int'(vecs[i].e_aa));
      chk($sformatf("v%0d_commit_valid", i), int'(bus.commit_valid), int'(vecs[i].e_cv));
      chk($sformatf("v%0d_count", i), int'(bus.count), int'(vecs[i].e_cnt));
      chk($sformatf("v%0d_head", i), int'(bus.head_addr), int'(vecs[i].e_head));
      chk($sformatf("v%0d_empty", i), int'(bus.empty), int'(vecs[i].e_cnt == 0));
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d_commit_dst", i), int'(bus.commit_dst_addr), int'(vecs[i].e_cdst));
        chk($sformatf("v%0d_commit_dst_valid", i), int'(bus.commit_dst_valid), 1);
        chk($sformatf("v%0d_commit_data", i), int'(bus.commit_data), int'(vecs[i].e_cd));
        chk($sformatf("v%0d_commit_addr", i), int'(bus.commit_rob_addr), int'(vecs[i].e_head));
      end
      tick();
    end

    // Reset mid-operation: 5 live (slots 6,7,0,1,2), slots 7 and 6 done.
    for (int i = 0; i < 5; i++) begin
      set_alloc(4'(i + 1));
      #1 chk("a_alloc_addr", int'(bus.alloc_rob_addr), (6 + i) % 8);
      tick();
    end
    set_cmpl(3'd7, 8'h70);
    tick();
    set_cmpl(3'd6, 8'h60);
    tick();
    rst = 1'b1;
    #1;
    chk("a_rst_count_before", int'(bus.count), 5);
    chk("a_rst_cycle_commit", int'(bus.commit_valid), 0);
    tick();
    #1;
    chk("a_post_rst_count", int'(bus.count), 0);
    chk("a_post_rst_empty", int'(bus.empty), 1);
    chk("a_post_rst_commit", int'(bus.commit_valid), 0);
    chk("a_post_rst_alloc_addr", int'(bus.alloc_rob_addr), 0);
    chk("a_post_rst_ready", int'(bus.alloc_ready), 1);
    chk("a_post_rst_full", int'(bus.full), 0);

    // Fill to 8, refused 9th alloc, retire one, wrap-around alloc.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(4'(i + 1));
      #1 chk("b_alloc_addr", int'(bus.alloc_rob_addr), i);
      tick();
    end
    set_alloc(4'd15);
    #1;
    chk("b_full", int'(bus.full), 1);
    chk("b_ready_full", int'(bus.alloc_ready), 0);
    chk("b_count_full", int'(bus.count), 8);
    tick();
    #1;
    chk("b_9th_tail_unchanged", int'(bus.alloc_rob_addr), 0);
    chk("b_9th_count", int'(bus.count), 8);
    set_cmpl(3'd0, 8'hA0);
    tick();
    set_alloc(4'd9);
    #1;
    chk("b_full_commit_ready", int'(bus.alloc_ready), 0);
    chk("b_full_commit_valid", int'(bus.commit_valid), 1);
    chk("b_full_commit_data", int'(bus.commit_data), 8'hA0);
    chk("b_full_commit_dst", int'(bus.commit_dst_addr), 1);
    tick();
    #1;
    chk("b_after_commit_count", int'(bus.count), 7);
    chk("b_after_commit_ready", int'(bus.alloc_ready), 1);
    chk("b_wrap_alloc_addr", int'(bus.alloc_rob_addr), 0);
    chk("b_after_commit_head", int'(bus.head_addr), 1);
    set_alloc(4'd9);
    tick();
    #1;
    chk("b_wrap_count", int'(bus.count), 8);
    chk("b_wrap_full", int'(bus.full), 1);
    chk("b_wrap_tail", int'(bus.alloc_rob_addr), 1);

    // Flush keeps 0..2 of 6 live; stale cmpl and non-live flush are ignored.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(4'(i + 1));
      tick();
    end
    #1 chk("c_count6", int'(bus.count), 6);
    bus.flush_valid    = 1'b1;
    bus.flush_rob_addr = 3'd2;
    set_alloc(4'd7);
    #1 chk("c_flush_blocks_alloc", int'(bus.alloc_ready), 0);
    tick();
    #1;
    chk("c_flush_count", int'(bus.count), 3);
    chk("c_flush_alloc_addr", int'(bus.alloc_rob_addr), 3);
    chk("c_flush_head", int'(bus.head_addr), 0);
    set_cmpl(3'd4, 8'h99);
    tick();
    #1;
    chk("c_stale_cmpl_count", int'(bus.count), 3);
    chk("c_stale_cmpl_commit", int'(bus.commit_valid), 0);
    bus.flush_valid    = 1'b1;
    bus.flush_rob_addr = 3'd5;
    tick();
    #1 chk("c_nonlive_flush_count", int'(bus.count), 3);

    // Same cycle: flush + alloc + cmpl to squashed entry + head commit.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(4'(8 + i));
      tick();
    end
    set_cmpl(3'd0, 8'h5A);
    tick();
    bus.flush_valid    = 1'b1;
    bus.flush_rob_addr = 3'd1;
    set_alloc(4'd12);
    set_cmpl(3'd3, 8'h77);
    #1;
    chk("d_ready", int'(bus.alloc_ready), 0);
    chk("d_commit_valid", int'(bus.commit_valid), 1);
    chk("d_commit_dst", int'(bus.commit_dst_addr), 8);
    chk("d_commit_data", int'(bus.commit_data), 8'h5A);
    tick();
    #1;
    chk("d_count", int'(bus.count), 1);
    chk("d_head", int'(bus.head_addr), 1);
    chk("d_tail", int'(bus.alloc_rob_addr), 2);
    set_cmpl(3'd1, 8'h31);
    tick();
    bus.flush_valid    = 1'b1;
    bus.flush_rob_addr = 3'd1;
    #1;
    chk("d_head_flush_commit", int'(bus.commit_valid), 1);
    chk("d_head_flush_data", int'(bus.commit_data), 8'h31);
    chk("d_head_flush_dst", int'(bus.commit_dst_addr), 9);
    tick();
    #1;
    chk("d_empty_after", int'(bus.empty), 1);
    chk("d_count_after", int'(bus.count), 0);
    chk("d_head_after", int'(bus.head_addr), 2);
    chk("d_tail_after", int'(bus.alloc_rob_addr), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
